// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) engines over a
// word-addressed array with FIXED/INCR/WRAP bursts, byte strobes and SLVERR reporting.
module axi_mem_slave #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [7:0]          ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_last
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input burst_t            burst
  );
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    step = ADDR_W'(1) << size;
    mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | ((a + step) & mask);
      default:     next_addr = a + step;
    endcase
  endfunction

  function automatic logic beat_err(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input burst_t            burst
  );
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    beat_err = (burst == BURST_RSVD) || (32'(size) > LB) || bad_wrap ||
               ((a >> LB) >= ADDR_W'(MEM_DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    word_idx = IW'(a >> LB);
  endfunction

  // Write channel state
  wstate_t           w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  burst_t            w_burst;
  logic [7:0]        w_cnt;
  logic              w_err;

  // Read channel state
  rstate_t           r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  burst_t            r_burst;
  logic [7:0]        r_cnt;

  logic              w_beat_err;
  logic              w_last_bad;
  logic              w_hs;
  logic [ADDR_W-1:0] w_nxt;
  logic              ar_err;
  logic [ADDR_W-1:0] r_nxt;
  logic              r_nerr;

  always_comb begin
    w_beat_err = beat_err(w_addr, w_len, w_size, w_burst);
    w_last_bad = w_last != (w_cnt == w_len);
    w_hs       = (w_state == W_DATA) && w_valid && w_ready;
    w_nxt      = next_addr(w_addr, w_len, w_size, w_burst);
    ar_err     = beat_err(ar_addr, ar_len, ar_size, burst_t'(ar_burst));
    r_nxt      = next_addr(r_addr, r_len, r_size, r_burst);
    r_nerr     = beat_err(r_nxt, r_len, r_size, r_burst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      w_addr   <= '0;
      w_len    <= '0;
      w_size   <= '0;
      w_burst  <= BURST_FIXED;
      w_cnt    <= '0;
      w_err    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready <= 1'b1;
          if (aw_valid && aw_ready) begin
            w_addr   <= aw_addr;
            w_len    <= aw_len;
            w_size   <= aw_size;
            w_burst  <= burst_t'(aw_burst);
            w_cnt    <= '0;
            w_err    <= 1'b0;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // The beat count, not w_last, terminates the burst.
            if (w_cnt == w_len) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_resp  <= (w_err || w_beat_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= w_nxt;
              w_err  <= w_err || w_beat_err || w_last_bad;
            end
          end
        end
        W_RESP: begin
          if (b_ready) begin
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_hs && !w_beat_err) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      r_last   <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= BURST_FIXED;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready <= 1'b1;
          if (ar_valid && ar_ready) begin
            r_addr   <= ar_addr;
            r_len    <= ar_len;
            r_size   <= ar_size;
            r_burst  <= burst_t'(ar_burst);
            r_cnt    <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_data   <= ar_err ? '0 : mem[word_idx(ar_addr)];
            r_resp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            r_last   <= (ar_len == 8'd0);
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          // Outputs only move on a handshake, so they hold through stalls.
          if (r_valid && r_ready) begin
            if (r_cnt == r_len) begin
              r_valid  <= 1'b0;
              r_data   <= '0;
              r_resp   <= RESP_OKAY;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_addr <= r_nxt;
              r_data <= r_nerr ? '0 : mem[word_idx(r_nxt)];
              r_resp <= r_nerr ? RESP_SLVERR : RESP_OKAY;
              r_last <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Parametrised AXI4 memory slave: accepts AW/W/B and AR/R bursts and stores data in an internal word-addressed array.
- Supports all `burst_t` modes (FIXED, INCR, WRAP), narrow transfers, byte strobes and `resp_t` error signalling.
- Successor to the fixed 32-bit channel definitions, generalised in data and address width.
- Backing store for the core's instruction/data bus in simulation and FPGA builds.

Parameters:
- DATA_W, 32, data bus width in bits; 32 or 64.
- ADDR_W, 32, byte address width.
- MEM_DEPTH, 1024, number of DATA_W-bit words in the array.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aw_valid/aw_ready  in/out  1  write-address handshake
- aw_addr  in  ADDR_W  burst start byte address
- aw_len  in  8  beats minus 1
- aw_size  in  3  log2 bytes per beat
- aw_burst  in  2  burst type
- w_valid/w_ready  in/out  1  write-data handshake
- w_data  in  DATA_W  write data
- w_strb  in  DATA_W/8  byte enables
- w_last  in  1  master's last-beat flag
- b_valid/b_ready  out/in  1  write-response handshake
- b_resp  out  2  write response
- ar_valid/ar_ready, ar_addr, ar_len, ar_size, ar_burst: read-address channel, same widths and meaning as AW
- r_valid/r_ready  out/in  1  read-data handshake
- r_data  out  DATA_W  read data
- r_resp  out  2  read response
- r_last  out  1  final read beat

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- During reset:
  - All outputs are 0.
  - Both FSMs go to idle and any in-flight burst is aborted.
  - Memory contents are retained, not cleared.
- First cycle after reset: aw_ready=1, ar_ready=1.
- Channel independence: write and read FSMs are independent. The array has one write port and one read port.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready=1. On the AW handshake, latch addr/len/size/burst, set beat count to 0, clear the error flag, go to W_DATA.
  - W_DATA: w_ready=1. On each W handshake, write every byte lane whose w_strb bit is set into word `addr>>log2(DATA_W/8)`, then advance the address.
  - After beat len+1, go to W_RESP. The beat count, not w_last, ends the burst.
  - W_RESP: b_valid=1 with b_resp. Hold until b_ready, then go to W_IDLE.
  - B latency: b_valid rises the cycle after the last W handshake.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready=1. AR handshake in cycle N gives r_valid=1 in cycle N+1 with beat 0.
  - R_DATA: on each R handshake, present the next beat in the following cycle (no bubbles).
  - r_data, r_resp and r_last stay stable while r_valid && !r_ready.
  - r_last=1 on beat len only. The R handshake on that beat returns the FSM to R_IDLE, so ar_ready is 1 the next cycle.
- Address generation, per beat, with step = 1<<size:
  - FIXED: address is unchanged.
  - INCR: addr += step, modulo 2^ADDR_W.
  - WRAP: boundary = (len+1)*step. Next address = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Per-beat error conditions, each giving SLVERR:
  - burst == 3 (reserved);
  - size > log2(DATA_W/8);
  - WRAP with len not in {1,3,7,15};
  - word index >= MEM_DEPTH.
  - On an erroring beat, writes are suppressed and reads return r_data=0.
- Response reporting:
  - r_resp is evaluated per beat.
  - b_resp = SLVERR if any beat erred, else OKAY.
  - b_resp is also SLVERR if w_last disagrees with the final-beat position on any beat.
  - EXOKAY and DECERR are never produced.
- Collisions:
  - A read of a word written in the same cycle returns the old data.
  - A write is visible to reads from the next cycle.
- Narrow transfers: data lanes are taken from w_strb as given. Read returns the full word.

Test Plan:
- Single INCR write of addr 0x10, len 0, size 2, data 0xDEADBEEF, strb 0xF, then read of the same -> b_resp OKAY one cycle after the W beat; r_valid at N+1 with r_data 0xDEADBEEF, r_last=1.
- INCR write of 4 beats at 0x0, size 2, data 1..4, with random b_ready/r_ready stalls, then INCR read of 4 -> reads return 1,2,3,4; r_data held stable during stalls; r_last only on beat 3.
- WRAP read at 0x18, len 3, size 2 -> beat addresses 0x18, 0x1C, 0x10, 0x14. WRAP with len 2 -> all beats SLVERR.
- Write with strb 0x3 of data 0xAAAA5555 over word 0x12345678 -> reads back 0x12345555. FIXED write of 3 beats to 0x20 -> final value is the last beat's data.
- Write to word index MEM_DEPTH, and a burst with w_last asserted on beat 1 of 4 -> both return b_resp SLVERR; the out-of-range write changes no memory; read of index MEM_DEPTH returns r_data 0, r_resp SLVERR.
- rst asserted during beat 2 of an 8-beat write -> outputs 0 during reset; aw_ready=ar_ready=1 after reset; beats 0-1 retained in memory; no b_valid issued.
